// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: multi-cycle AES InvSubBytes using LANES shared S-box lanes; AES_SUBBYTES_ENC_EN adds a forward-S-box select
module inv_sub_bytes_seq #(
   parameter int LANES = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] state_in_i,
`ifdef AES_SUBBYTES_ENC_EN
   input  logic         inv_i,
`endif
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] state_out_o,
   output logic         busy_o
);
   localparam int C  = 16 / LANES;
   localparam int CW = (C > 1) ? $clog2(C) : 1;

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

`ifdef AES_SUBBYTES_ENC_EN
   localparam logic [2047:0] FWD_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic inv_q;

   function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
      return inv ? INV_SBOX[{~x, 3'b000} +: 8] : FWD_SBOX[{~x, 3'b000} +: 8];
   endfunction
`else
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return INV_SBOX[{~x, 3'b000} +: 8];
   endfunction
`endif

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e          state_q;
   logic [127:0]    buf_q, buf_d;
   logic [CW-1:0]   cnt_q;
   logic            out_valid_q, busy_q;
   logic            last;

   assign last        = cnt_q == CW'(C - 1);
   assign in_ready_o  = (state_q == IDLE) || (state_q == DONE && out_ready_i);
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;
   assign state_out_o = buf_q;

   // substitute the byte group selected by cnt_q, one S-box lookup per lane
   always_comb begin
      buf_d = buf_q;
      for (int l = 0; l < LANES; l++) begin
         automatic logic [6:0] off = {4'(15 - (int'(cnt_q) * LANES + l)), 3'b000};
`ifdef AES_SUBBYTES_ENC_EN
         buf_d[off +: 8] = sbox(buf_q[off +: 8], inv_q);
`else
         buf_d[off +: 8] = sbox(buf_q[off +: 8]);
`endif
      end
   end

   // IDLE/RUN/DONE control with registered out_valid and busy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef AES_SUBBYTES_ENC_EN
         inv_q       <= 1'b1;
`endif
      end else if (state_q == RUN) begin
         buf_q <= buf_d;
         cnt_q <= last ? '0 : cnt_q + 1'b1;
         if (last) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
         end
      end else if (in_valid_i && in_ready_o) begin
         buf_q       <= state_in_i;
         cnt_q       <= '0;
         state_q     <= RUN;
         busy_q      <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef AES_SUBBYTES_ENC_EN
         inv_q       <= inv_i;
`endif
      end else if (out_ready_i) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end
   end
endmodule
